// File: rtl/if_debug_ctrl.sv
// rtl/if_debug_ctrl.sv - fetch-stage debug controller: serial program load plus run/step sequencing.
// Optional cycle counter is enabled by defining IF_DEBUG_CYCLE_COUNT_EN.
module if_debug_ctrl #(
  parameter int               NBITS     = 32,
  parameter int               TAM_I     = 256,
  parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  input  logic             i_halt,
  output logic [NBITS-1:0] o_address_memory_ins,
  output logic [NBITS-1:0] o_instruction,
  output logic             o_write_intruc,
  output logic             o_step,
  output logic [2:0]       o_state,
  output logic [NBITS-1:0] o_words_loaded,
  output logic             o_load_error,
  output logic             o_done,
  output logic [NBITS-1:0] o_cycle_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    STEP = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [7:0]       CMD_LOAD   = 8'h4C;
  localparam logic [7:0]       CMD_RUN    = 8'h43;
  localparam logic [7:0]       CMD_STEP   = 8'h53;
  localparam logic [7:0]       CMD_NEXT   = 8'h4E;
  localparam logic [7:0]       CMD_EXIT   = 8'h45;
  localparam logic [NBITS-1:0] LAST_ADDR  = NBITS'(TAM_I - 4);
  localparam logic [NBITS-1:0] WORD_BYTES = NBITS'(4);
  localparam logic [NBITS-1:0] ONE        = NBITS'(1);

  state_t             state;
  logic [1:0]         byte_cnt;
  logic [NBITS-9:0]   shift;
  logic [NBITS-1:0]   wr_addr;
  logic [NBITS-1:0]   word;

  // The incoming byte completes the word on the fourth beat, so the write needs no extra stage.
  assign word    = {shift, i_rx_data};
  assign o_state = state;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state                <= IDLE;
      byte_cnt             <= 2'd0;
      shift                <= '0;
      wr_addr              <= '0;
      o_address_memory_ins <= '0;
      o_instruction        <= '0;
      o_write_intruc       <= 1'b0;
      o_step               <= 1'b0;
      o_words_loaded       <= '0;
      o_load_error         <= 1'b0;
      o_done               <= 1'b0;
    end else begin
      o_write_intruc <= 1'b0;
      o_done         <= 1'b0;
      case (state)
        IDLE: begin
          o_step <= 1'b0;
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_LOAD: begin
                state                <= LOAD;
                o_load_error         <= 1'b0;
                o_words_loaded       <= '0;
                byte_cnt             <= 2'd0;
                wr_addr              <= '0;
                o_address_memory_ins <= '0;
              end
              CMD_RUN: begin
                state  <= RUN;
                o_step <= 1'b1;
              end
              CMD_STEP: state <= STEP;
              default: ;
            endcase
          end
        end
        LOAD: begin
          if (i_rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              o_write_intruc       <= 1'b1;
              o_address_memory_ins <= wr_addr;
              o_instruction        <= word;
              wr_addr              <= wr_addr + WORD_BYTES;
              o_words_loaded       <= o_words_loaded + ONE;
              if (word == HALT_WORD) begin
                state <= IDLE;
              end else if (wr_addr == LAST_ADDR) begin
                o_load_error <= 1'b1;
                state        <= IDLE;
              end
            end else begin
              shift <= word[NBITS-9:0];
            end
          end
        end
        RUN: begin
          if (i_halt) begin
            o_step <= 1'b0;
            o_done <= 1'b1;
            state  <= DONE;
          end else begin
            o_step <= 1'b1;
          end
        end
        STEP: begin
          o_step <= 1'b0;
          // Halt outranks any byte in the same cycle, including a pending 'N' or 'E'.
          if (i_halt) begin
            o_done <= 1'b1;
            state  <= DONE;
          end else if (i_rx_valid) begin
            if (i_rx_data == CMD_NEXT) begin
              o_step <= 1'b1;
            end else if (i_rx_data == CMD_EXIT) begin
              state <= IDLE;
            end
          end
        end
        DONE: begin
          o_step <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_step <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef IF_DEBUG_CYCLE_COUNT_EN
  logic             session_start;
  logic [NBITS-1:0] cycle_cnt;

  assign session_start = (state == IDLE) && i_rx_valid &&
                         ((i_rx_data == CMD_RUN) || (i_rx_data == CMD_STEP));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cycle_cnt <= '0;
    end else if (session_start) begin
      cycle_cnt <= '0;
    end else if (o_step) begin
      cycle_cnt <= cycle_cnt + ONE;
    end
  end

  assign o_cycle_count = cycle_cnt;
`else
  assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_if_debug_ctrl.sv
// tb/tb_if_debug_ctrl.sv - directed self-checking bench for if_debug_ctrl.
module tb_if_debug_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] addr;
  logic [31:0] instr;
  logic        wr;
  logic        step;
  logic [2:0]  state;
  logic [31:0] words;
  logic        err;
  logic        done;
  logic [31:0] ccount;

  int checks = 0;
  int errors = 0;
  int n_wr = 0;
  int n_step = 0;
  int n_done = 0;
  logic [31:0] wr_addr_log [64];
  logic [31:0] wr_data_log [64];

  if_debug_ctrl #(.NBITS(32), .TAM_I(16), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .i_rx_data(rx_data),
    .i_rx_valid(rx_valid),
    .i_halt(halt),
    .o_address_memory_ins(addr),
    .o_instruction(instr),
    .o_write_intruc(wr),
    .o_step(step),
    .o_state(state),
    .o_words_loaded(words),
    .o_load_error(err),
    .o_done(done),
    .o_cycle_count(ccount)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr && n_wr < 64) begin
      wr_addr_log[n_wr] = addr;
      wr_data_log[n_wr] = instr;
    end
    if (wr) n_wr++;
    if (step) n_step++;
    if (done) n_done++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the next negedge with the byte sampled.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(t[31:24]);
      t = t << 8;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", addr); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instr); end
    checks++; if ({wr, step, err, done} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {wr, step, err, done}); end
    checks++; if (words !== 32'h0) begin errors++; $display("FAIL reset_words: got %0d expected 0", words); end
    checks++; if (ccount !== 32'h0) begin errors++; $display("FAIL reset_ccount: got %0d expected 0", ccount); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_overflow;
    int base;
    base = n_wr;
    send_byte(8'h4C);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL ovf_load_state: got %0d expected 1", state); end
    for (int i = 0; i < 4; i++) send_word(32'h0100_0000 + i);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL ovf_state_at_edge: got %0d expected 0", state); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err_at_edge: got %b expected 1", err); end
    send_word(32'h0100_0004);
    idle(2);
    checks++; if (n_wr - base !== 4) begin errors++; $display("FAIL ovf_nwrites: got %0d expected 4", n_wr - base); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wr_addr_log[base + k] !== 32'(4 * k) || wr_data_log[base + k] !== 32'h0100_0000 + k) begin
        errors++;
        $display("FAIL ovf_write%0d: got addr %h data %h expected addr %h data %h", k,
                 wr_addr_log[base + k], wr_data_log[base + k], 32'(4 * k), 32'h0100_0000 + k);
      end
    end
    checks++; if (words !== 32'd4) begin errors++; $display("FAIL ovf_words: got %0d expected 4", words); end
    checks++; if (err !== 1'b1 || state !== 3'd0) begin errors++; $display("FAIL ovf_final: got err %b state %0d expected err 1 state 0", err, state); end
  endtask

  task automatic test_load;
    int base;
    base = n_wr;
    send_byte(8'h4C);
    checks++; if (err !== 1'b0 || words !== 32'd0) begin errors++; $display("FAIL load_clear: got err %b words %0d expected 0 0", err, words); end
    send_word(32'h2008_0005);
    checks++; if (wr !== 1'b1 || addr !== 32'h0 || instr !== 32'h2008_0005) begin errors++; $display("FAIL load_latency: got wr %b addr %h data %h expected 1 0 20080005", wr, addr, instr); end
    send_word(32'hFFFF_FFFF);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL load_halt_state: got %0d expected 0", state); end
    idle(2);
    checks++; if (n_wr - base !== 2) begin errors++; $display("FAIL load_nwrites: got %0d expected 2", n_wr - base); end
    checks++; if (wr_addr_log[base + 1] !== 32'h4 || wr_data_log[base + 1] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL load_write1: got addr %h data %h expected 4 ffffffff", wr_addr_log[base + 1], wr_data_log[base + 1]); end
    checks++; if (words !== 32'd2 || err !== 1'b0) begin errors++; $display("FAIL load_result: got words %0d err %b expected 2 0", words, err); end
  endtask

  task automatic test_run;
    int s0, d0, guard;
    s0 = n_step;
    d0 = n_done;
    send_byte(8'h43);
    checks++; if (step !== 1'b1 || state !== 3'd2) begin errors++; $display("FAIL run_start: got step %b state %0d expected 1 2", step, state); end
    #1;
    guard = 0;
    while (n_step - s0 < 10 && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    checks++; if (step !== 1'b0 || done !== 1'b1 || state !== 3'd4) begin errors++; $display("FAIL run_halt: got step %b done %b state %0d expected 0 1 4", step, done, state); end
    idle(3);
    checks++; if (n_step - s0 !== 10) begin errors++; $display("FAIL run_steps: got %0d expected 10", n_step - s0); end
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL run_done: got %0d expected 1", n_done - d0); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL run_idle: got %0d expected 0", state); end
`ifdef IF_DEBUG_CYCLE_COUNT_EN
    checks++; if (ccount !== 32'd10) begin errors++; $display("FAIL run_ccount: got %0d expected 10", ccount); end
`else
    checks++; if (ccount !== 32'd0) begin errors++; $display("FAIL run_ccount: got %0d expected 0", ccount); end
`endif
  endtask

  task automatic test_step;
    int s0, d0;
    s0 = n_step;
    d0 = n_done;
    send_byte(8'h53);
    checks++; if (state !== 3'd3 || step !== 1'b0) begin errors++; $display("FAIL step_enter: got state %0d step %b expected 3 0", state, step); end
    send_byte(8'h4E);
    checks++; if (step !== 1'b1) begin errors++; $display("FAIL step_latency: got %b expected 1", step); end
    send_byte(8'h4E);
    send_byte(8'h58);
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL step_ignore_x: got %b expected 0", step); end
    send_byte(8'h4E);
    idle(2);
    checks++; if (n_step - s0 !== 3) begin errors++; $display("FAIL step_count: got %0d expected 3", n_step - s0); end
    send_byte(8'h45);
    idle(2);
    checks++; if (state !== 3'd0 || n_done - d0 !== 0) begin errors++; $display("FAIL step_exit: got state %0d dones %0d expected 0 0", state, n_done - d0); end
`ifdef IF_DEBUG_CYCLE_COUNT_EN
    checks++; if (ccount !== 32'd3) begin errors++; $display("FAIL step_ccount: got %0d expected 3", ccount); end
`else
    checks++; if (ccount !== 32'd0) begin errors++; $display("FAIL step_ccount: got %0d expected 0", ccount); end
`endif
  endtask

  task automatic test_collision;
    int s0, d0;
    send_byte(8'h53);
    s0 = n_step;
    d0 = n_done;
    rx_data  = 8'h4E;
    rx_valid = 1'b1;
    halt     = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    halt     = 1'b0;
    checks++; if (step !== 1'b0 || done !== 1'b1 || state !== 3'd4) begin errors++; $display("FAIL coll_edge: got step %b done %b state %0d expected 0 1 4", step, done, state); end
    idle(2);
    checks++; if (n_step - s0 !== 0 || n_done - d0 !== 1 || state !== 3'd0) begin errors++; $display("FAIL coll_final: got steps %0d dones %0d state %0d expected 0 1 0", n_step - s0, n_done - d0, state); end
  endtask

  task automatic test_reset_mid_load;
    int base;
    base = n_wr;
    send_byte(8'h4C);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state !== 3'd0 || words !== 32'd0 || addr !== 32'd0 || instr !== 32'd0) begin errors++; $display("FAIL rst_mid_async: got state %0d words %0d addr %h instr %h expected all 0", state, words, addr, instr); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    checks++; if (n_wr - base !== 0 || wr !== 1'b0) begin errors++; $display("FAIL rst_mid_nowrite: got writes %0d wr %b expected 0 0", n_wr - base, wr); end
    @(negedge clk);
    send_byte(8'h4C);
    send_word(32'h0A0B_0C0D);
    checks++; if (wr !== 1'b1 || addr !== 32'h0 || instr !== 32'h0A0B_0C0D) begin errors++; $display("FAIL rst_mid_fresh: got wr %b addr %h data %h expected 1 0 0a0b0c0d", wr, addr, instr); end
    send_word(32'hFFFF_FFFF);
    idle(2);
    checks++; if (words !== 32'd2 || state !== 3'd0) begin errors++; $display("FAIL rst_mid_reload: got words %0d state %0d expected 2 0", words, state); end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_load();
    test_run();
    test_step();
    test_collision();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
